// File: rtl/fft_mag_unload.sv
// FFT result unload: walks bins 0..N/2-1 of the result RAM and
// streams squared magnitudes re^2+im^2 over valid/ready.
module fft_mag_unload #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               done,
  output logic [N_2-1:0]     rdadr,
  input  logic [2*width-1:0] rd,
  output logic [2*width-1:0] out_data,
  output logic [N_2-2:0]     out_bin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               overrun
);

  localparam int W2 = 2 * width;
  localparam logic [N_2-1:0] LAST_ADR = N_2'((2 ** (N_2 - 1)) - 1);
  localparam logic [N_2-2:0] LAST_BIN = '1;
  localparam logic [N_2-1:0] ONE      = N_2'(1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             done_q, done_d;
  logic             armed_q, armed_d;
  logic             overrun_q, overrun_d;
  logic [N_2-1:0]   rdadr_q, rdadr_d;

  logic             s0_valid_q, s0_valid_d;
  logic [width-1:0] s0_re_q, s0_re_d;
  logic [width-1:0] s0_im_q, s0_im_d;
  logic [N_2-2:0]   s0_bin_q, s0_bin_d;

  logic             s1_valid_q, s1_valid_d;
  logic [W2-1:0]    sq_re_q, sq_re_d;
  logic [W2-1:0]    sq_im_q, sq_im_d;
  logic [N_2-2:0]   s1_bin_q, s1_bin_d;

  logic             out_valid_q, out_valid_d;
  logic [W2-1:0]    out_data_q, out_data_d;
  logic [N_2-2:0]   out_bin_q, out_bin_d;
  logic             out_last_q, out_last_d;

  logic adv;
  logic start;
  logic signed [W2-1:0] re_x;
  logic signed [W2-1:0] im_x;

  // armed blocks a start from a done level already high out of reset
  always_comb begin
    adv   = ~out_valid_q | out_ready;
    start = done & ~done_q & armed_q;
    re_x  = {{width{s0_re_q[width-1]}}, s0_re_q};
    im_x  = {{width{s0_im_q[width-1]}}, s0_im_q};

    state_d     = state_q;
    done_d      = done;
    armed_d     = armed_q | ~done;
    overrun_d   = overrun_q | (start & (state_q != IDLE));
    rdadr_d     = rdadr_q;
    s0_valid_d  = s0_valid_q;
    s0_re_d     = s0_re_q;
    s0_im_d     = s0_im_q;
    s0_bin_d    = s0_bin_q;
    s1_valid_d  = s1_valid_q;
    sq_re_d     = sq_re_q;
    sq_im_d     = sq_im_q;
    s1_bin_d    = s1_bin_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_bin_d   = out_bin_q;
    out_last_d  = out_last_q;

    unique case (1'b1)
      (state_q == IDLE): begin
        if (start) begin
          state_d = RUN;
          rdadr_d = '0;
        end
      end
      (state_q == RUN): begin
        if (adv) begin
          rdadr_d = rdadr_q + ONE;
          if (rdadr_q == LAST_ADR) state_d = DRAIN;
        end
      end
      (state_q == DRAIN): begin
        if (out_valid_q & out_ready & out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      s0_valid_d  = (state_q == RUN);
      s0_re_d     = rd[W2-1:width];
      s0_im_d     = rd[width-1:0];
      s0_bin_d    = rdadr_q[N_2-2:0];
      s1_valid_d  = s0_valid_q;
      sq_re_d     = re_x * re_x;
      sq_im_d     = im_x * im_x;
      s1_bin_d    = s0_bin_q;
      out_valid_d = s1_valid_q;
      out_data_d  = sq_re_q + sq_im_q;
      out_bin_d   = s1_bin_q;
      out_last_d  = s1_valid_q & (s1_bin_q == LAST_BIN);
    end
  end

  // state, read address and pipeline registers
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      armed_q     <= 1'b0;
      overrun_q   <= 1'b0;
      rdadr_q     <= '0;
      s0_valid_q  <= 1'b0;
      s0_re_q     <= '0;
      s0_im_q     <= '0;
      s0_bin_q    <= '0;
      s1_valid_q  <= 1'b0;
      sq_re_q     <= '0;
      sq_im_q     <= '0;
      s1_bin_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bin_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      armed_q     <= armed_d;
      overrun_q   <= overrun_d;
      rdadr_q     <= rdadr_d;
      s0_valid_q  <= s0_valid_d;
      s0_re_q     <= s0_re_d;
      s0_im_q     <= s0_im_d;
      s0_bin_q    <= s0_bin_d;
      s1_valid_q  <= s1_valid_d;
      sq_re_q     <= sq_re_d;
      sq_im_q     <= sq_im_d;
      s1_bin_q    <= s1_bin_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bin_q   <= out_bin_d;
      out_last_q  <= out_last_d;
    end
  end

  assign rdadr     = rdadr_q;
  assign out_data  = out_data_q;
  assign out_bin   = out_bin_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_fft_mag_unload.sv
// Bench for fft_mag_unload: random and directed frames
// checked against an arithmetic magnitude model.
module tb_fft_mag_unload;

  logic        clk = 1'b0;
  logic        nreset;
  logic        done;
  logic [4:0]  rdadr;
  logic [31:0] rd;
  logic [31:0] out_data;
  logic [3:0]  out_bin;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  logic [31:0] ram [32];
  logic [31:0] got [16];

  always #5 clk = ~clk;

  assign rd = ram[rdadr];

  fft_mag_unload #(.width(16), .N_2(5)) dut (
    .clk(clk), .nreset(nreset), .done(done), .rdadr(rdadr),
    .rd(rd), .out_data(out_data), .out_bin(out_bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  function automatic logic [31:0] model(input int k);
    longint re, im, s;
    re = longint'($signed(ram[k][31:16]));
    im = longint'($signed(ram[k][15:0]));
    s  = re * re + im * im;
    return s[31:0];
  endfunction

  function automatic logic pick(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return 1'($urandom % 2);
    endcase
  endfunction

  task automatic pulse_done();
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
  endtask

  // Drives out_ready at negedges and scores each beat that will be
  // taken at the next posedge.
  task automatic collect(input int mode, input int nbeats);
    int idx = 0;
    int cyc = 0;
    logic stall = 1'b0;
    logic [31:0] hd = '0;
    logic [3:0] hb = '0;
    while (idx < nbeats && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        total++;
        if (!out_valid || out_data !== hd || out_bin !== hb) begin
          bad++;
          $display("FAIL stall_hold v=%0b bin=%0d data=%h need bin=%0d data=%h",
                   out_valid, out_bin, out_data, hb, hd);
        end
      end
      out_ready = pick(mode, cyc);
      if (out_valid && out_ready) begin
        total++;
        if (out_bin !== 4'(idx) || out_data !== model(idx) ||
            out_last !== (idx == 15)) begin
          bad++;
          $display("FAIL beat%0d bin=%0d data=%h last=%0b need bin=%0d data=%h last=%0b",
                   idx, out_bin, out_data, out_last, idx, model(idx), idx == 15);
        end
        got[idx] = out_data;
        idx++;
      end
      stall = out_valid && !out_ready;
      hd = out_data;
      hb = out_bin;
    end
    total++;
    if (idx != nbeats) begin
      bad++;
      $display("FAIL timeout beats=%0d need %0d", idx, nbeats);
    end
    if (nbeats == 16) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL frame_end busy=%0b valid=%0b need 0 0", busy, out_valid);
      end
    end
  endtask

  task automatic test_reset();
    int seen = 0;
    nreset = 1'b0; done = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (out_valid !== 0 || busy !== 0 || overrun !== 0 ||
        out_data !== 0 || out_bin !== 0 || out_last !== 0 || rdadr !== 0) begin
      bad++;
      $display("FAIL reset_vals v=%0b b=%0b o=%0b d=%h bin=%0d l=%0b a=%0d need zeros",
               out_valid, busy, overrun, out_data, out_bin, out_last, rdadr);
    end
    nreset = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL done_high_at_reset active_cycles=%0d need 0", seen);
    end
    done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic();
    int edges = 0;
    for (int k = 0; k < 32; k++) ram[k] = {16'(k), 16'h0};
    out_ready = 1'b1;
    @(negedge clk); done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    while (edges < 10 && !out_valid) begin
      @(posedge clk); #1 edges++;
      if (edges == 1) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL busy_start got %0b need 1", busy);
        end
      end
    end
    total++;
    if (edges != 3) begin
      bad++;
      $display("FAIL latency got %0d edges need 3", edges);
    end
    collect(0, 16);
    for (int k = 0; k < 16; k++) begin
      total++;
      if (got[k] !== 32'(k * k)) begin
        bad++;
        $display("FAIL basic_sq%0d got %h need %h", k, got[k], 32'(k * k));
      end
    end
  endtask

  task automatic test_corners();
    logic [31:0] need [5];
    for (int k = 0; k < 32; k++) ram[k] = $urandom;
    ram[1] = {16'sd3, 16'sd4};
    ram[2] = {16'h8000, 16'h8000};
    ram[3] = {16'hFFFF, 16'h0001};
    ram[4] = {16'h7FFF, 16'h8000};
    need[1] = 32'd25;
    need[2] = 32'h8000_0000;
    need[3] = 32'd2;
    need[4] = 32'h7FFF_0001;
    pulse_done();
    collect(0, 16);
    for (int k = 1; k < 5; k++) begin
      total++;
      if (got[k] !== need[k]) begin
        bad++;
        $display("FAIL corner%0d got %h need %h", k, got[k], need[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 32; k++) ram[k] = $urandom;
    pulse_done();
    collect(1, 16);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 32; k++) ram[k] = $urandom;
      pulse_done();
      collect(2, 16);
    end
  endtask

  task automatic test_level_retrigger();
    int seen = 0;
    out_ready = 1'b1;
    @(negedge clk); done = 1'b1;
    collect(0, 16);
    repeat (80) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    done = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL level_retrig active_cycles=%0d need 0", seen);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL level_overrun got %0b need 0", overrun);
    end
    out_ready = 1'b0;
    pulse_done();
    repeat (4) @(negedge clk);
    pulse_done();
    collect(1, 16);
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set got %0b need 1", overrun);
    end
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (overrun !== 1'b1 || seen != 0) begin
      bad++;
      $display("FAIL overrun_sticky ovr=%0b extra=%0d need 1 0", overrun, seen);
    end
  endtask

  task automatic test_reset_midframe();
    for (int k = 0; k < 32; k++) ram[k] = $urandom;
    pulse_done();
    collect(0, 6);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_bin !== 4'd6) begin
      bad++;
      $display("FAIL pre_abort v=%0b bin=%0d need 1 6", out_valid, out_bin);
    end
    nreset = 1'b0;
    #1;
    total++;
    if (out_valid !== 0 || busy !== 0 || overrun !== 0) begin
      bad++;
      $display("FAIL async_abort v=%0b b=%0b o=%0b need 0 0 0",
               out_valid, busy, overrun);
    end
    @(negedge clk); nreset = 1'b1;
    repeat (2) @(negedge clk);
    pulse_done();
    collect(2, 16);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_after_reset got %0b need 0", overrun);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) ram[k] = '0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_random();
    test_level_retrigger();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_mag_unload.md
Name: fft_mag_unload

Overview:
- Downstream consumer of the FFT core's result RAM.
- On each FFT completion, walks the first N/2 output bins (bins 0..N/2-1, the non-redundant half for real input) in natural order.
- Computes each bin's squared magnitude re^2 + im^2 and streams it out over a valid/ready interface.
- Feeds the spectrum/peak-detect logic and the host readout path.

Parameters:
- width, 16, bit width of each real/imag component in the result word (result word is 2*width).
- N_2, 5, log2 of FFT points; bins emitted = 2**(N_2-1).

Ports:
- clk  in  1  system clock; all state changes on posedge.
- nreset  in  1  asynchronous active-low reset.
- done  in  1  FFT done level; a rising edge starts one unload frame.
- rdadr  out  N_2  result RAM read address (bin index).
- rd  in  2*width  result word {re[2w-1:w], im[w-1:0]}, signed; combinational read, valid in the same cycle as rdadr.
- out_data  out  2*width  unsigned re^2+im^2.
- out_bin  out  N_2-1  bin index of out_data.
- out_valid  out  1  out_data/out_bin/out_last valid.
- out_ready  in  1  downstream accepts when out_valid & out_ready at posedge.
- out_last  out  1  high with the final bin (2**(N_2-1)-1).
- busy  out  1  frame in progress.
- overrun  out  1  sticky: a done rising edge arrived while busy.

Behaviour:
- Reset (async, nreset=0): state=IDLE; rdadr=0, out_valid=0, out_last=0, out_data=0, out_bin=0, busy=0, overrun=0; done edge-detect register=0; pipeline valid bits=0.
- Start condition: done=1 & done_q=0, where done_q is done registered every cycle.
  - Only the rising edge counts; a level held high does not retrigger.
  - If done is already 1 when reset releases, no frame starts.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on the start condition; rdadr=0, busy=1 from the next cycle.
- Pipeline advance enable: adv = ~out_valid | out_ready.
- Stage 1 (on adv, in RUN): registers re*re and im*im (signed products, 2*width bits each) plus the bin index, and sets s1_valid.
  - Then rdadr increments.
  - When rdadr = 2**(N_2-1)-1 is consumed, go to DRAIN.
- Stage 2 (on adv): out_data <= sq_re + sq_im, summed as unsigned 2*width bits.
  - Max is 2^(2w-1), so no overflow for any inputs including -2^(w-1).
  - out_bin/out_last follow the data; out_valid <= s1_valid.
- With adv=0, every pipeline register and rdadr holds; rd is re-read at the held address. The upstream RAM must not change during a frame.
- DRAIN -> IDLE on the cycle out_last is accepted (out_valid & out_ready & out_last); busy drops the same edge.
- Latency: with out_ready=1, first out_valid is seen 3 posedges after the edge that samples the start condition. One bin per cycle thereafter; the frame spans 2**(N_2-1) consecutive valid cycles.
- Backpressure:
  - out_valid, once asserted, stays high with stable out_data/out_bin/out_last until accepted.
  - No bin is dropped or duplicated.
- A start condition while busy is ignored (the frame is not restarted) and sets overrun=1. overrun is cleared only by reset.
- An async reset mid-frame aborts immediately to the reset values; a later done edge starts a fresh frame from bin 0.

Test Plan:
- Basic (width=16, N_2=5, out_ready=1): RAM bin k = {re=k, im=0}; pulse done -> 16 beats, out_bin 0..15, out_data=k^2 (0,1,4..225), out_last only on bin 15, first valid 3 edges after the done edge, busy falls after bin 15.
- Arithmetic corners: bin1 = {3,4} -> 25; bin2 = {-32768,-32768} -> 0x80000000; bin3 = {-1,1} -> 2; bin4 = {32767,-32768} -> 0x7FFF0001.
- Backpressure: out_ready toggles 1,0,0,1 repeating -> out_data/out_bin stable while stalled, all 16 bins delivered exactly once in order, no beat lost at the stall boundary.
- Level/retrigger: done held high 100 cycles -> exactly one frame; a second rising edge mid-frame -> frame completes normally, overrun=1 and remains 1.
- Reset mid-frame: drop nreset at bin 6 -> out_valid=0 and busy=0 asynchronously; next done edge -> out_bin restarts at 0, overrun=0.
